// File: rtl/ql_bitstream_loader.sv
// Memory-bank configuration loader: streams bit-line words row by row, pulses one word line per row,
// then releases the fabric reset. Optional end-of-load XOR checksum word under QL_CFG_CHECKSUM_EN.
module ql_bitstream_loader #(
   parameter int BL_WIDTH      = 514,
   parameter int WL_WIDTH      = 407,
   parameter int DATA_WIDTH    = 32,
   parameter int WL_PULSE      = 2,
   parameter int RELEASE_DELAY = 4
) (
   input  logic                  clk,
   input  logic                  global_resetn,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic [0:BL_WIDTH-1]   bl_config_region_0,
   output logic [0:WL_WIDTH-1]   wl_config_region_0,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  fabric_resetn
);

   localparam int WPR    = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
   localparam int WORD_W = $clog2(WPR + 1);
   localparam int PUL_W  = $clog2(WL_PULSE + 1);
   localparam int REL_W  = $clog2(RELEASE_DELAY + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
`ifdef QL_CFG_CHECKSUM_EN
   localparam logic [2:0] S_CHECK = 3'd5;
`endif

   // Handshake: a word moves on a rising edge where cfg_valid && cfg_ready; cfg_ready is a
   // registered decode of the FSM state and never looks at cfg_valid.
   logic [2:0]            state_q, state_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [WORD_W-1:0]     word_q, word_d;
   logic [PUL_W-1:0]      pulse_q, pulse_d;
   logic [REL_W-1:0]      rel_q, rel_d;
   logic [0:BL_WIDTH-1]   bl_q, bl_d;
   logic [0:WL_WIDTH-1]   wl_q, wl_d;
   logic                  cfg_ready_q, cfg_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  frst_q, frst_d;
   logic                  chk_fail;
   logic                  accept;
`ifdef QL_CFG_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_q, xor_d;
   logic                  err_q, err_d;
   assign chk_fail = err_q;
`else
   assign chk_fail = 1'b0;
`endif

   assign accept = cfg_valid && cfg_ready_q;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      word_d  = word_q;
      pulse_d = pulse_q;
      rel_d   = rel_q;
      bl_d    = bl_q;
      frst_d  = frst_q;
`ifdef QL_CFG_CHECKSUM_EN
      xor_d   = xor_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               row_d   = '0;
               word_d  = '0;
               bl_d    = '0;
`ifdef QL_CFG_CHECKSUM_EN
               xor_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            if (accept) begin
               // Word k lands on bit lines k*DATA_WIDTH.. ; indices past BL_WIDTH simply do not exist.
               for (int i = 0; i < BL_WIDTH; i++) begin
                  if ((i / DATA_WIDTH) == int'(word_q)) bl_d[i] = cfg_data[i % DATA_WIDTH];
               end
`ifdef QL_CFG_CHECKSUM_EN
               xor_d = xor_q ^ cfg_data;
`endif
               if (word_q == WORD_W'(WPR - 1)) begin
                  state_d = S_PULSE;
                  pulse_d = '0;
                  word_d  = '0;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end
         S_PULSE: begin
            if (pulse_q == PUL_W'(WL_PULSE - 1)) state_d = S_GAP;
            else                                 pulse_d = pulse_q + 1'b1;
         end
         S_GAP: begin
            if (row_q == ROW_W'(WL_WIDTH - 1)) begin
`ifdef QL_CFG_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
               rel_d   = '0;
`endif
            end else begin
               state_d = S_LOAD;
               row_d   = row_q + 1'b1;
               word_d  = '0;
               bl_d    = '0;
            end
         end
`ifdef QL_CFG_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               state_d = S_DONE;
               rel_d   = '0;
               err_d   = (cfg_data != xor_q);
            end
         end
`endif
         S_DONE: begin
            // A failed checksum keeps the fabric in reset until the loader itself is reset.
            if (rel_q != REL_W'(RELEASE_DELAY - 1)) rel_d  = rel_q + 1'b1;
            else if (!chk_fail)                     frst_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wl_d = '0;
      if (state_d == S_PULSE) wl_d[row_d] = 1'b1;
`ifdef QL_CFG_CHECKSUM_EN
      cfg_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
      busy_d      = (state_d == S_LOAD) || (state_d == S_PULSE) || (state_d == S_GAP) ||
                    (state_d == S_CHECK);
`else
      cfg_ready_d = (state_d == S_LOAD);
      busy_d      = (state_d == S_LOAD) || (state_d == S_PULSE) || (state_d == S_GAP);
`endif
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!global_resetn) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         word_q      <= '0;
         pulse_q     <= '0;
         rel_q       <= '0;
         bl_q        <= '0;
         wl_q        <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frst_q      <= 1'b0;
`ifdef QL_CFG_CHECKSUM_EN
         xor_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         word_q      <= word_d;
         pulse_q     <= pulse_d;
         rel_q       <= rel_d;
         bl_q        <= bl_d;
         wl_q        <= wl_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frst_q      <= frst_d;
`ifdef QL_CFG_CHECKSUM_EN
         xor_q       <= xor_d;
         err_q       <= err_d;
`endif
      end
   end

   assign cfg_ready          = cfg_ready_q;
   assign bl_config_region_0 = bl_q;
   assign wl_config_region_0 = wl_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign err                = chk_fail;
   assign fabric_resetn      = frst_q;

endmodule

// File: tb/tb_ql_bitstream_loader.sv
// Self-checking bench for ql_bitstream_loader: random/patterned full loads, stall, mid-row reset,
// release timing and (with QL_CFG_CHECKSUM_EN) checksum pass/fail.
module tb_ql_bitstream_loader;
   localparam int BL_WIDTH      = 514;
   localparam int WL_WIDTH      = 407;
   localparam int DW            = 32;
   localparam int WL_PULSE      = 2;
   localparam int RELEASE_DELAY = 4;
   localparam int WPR           = (BL_WIDTH + DW - 1) / DW;
   localparam int EW            = BL_WIDTH + 16;
`ifdef QL_CFG_CHECKSUM_EN
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic                clk;
   logic                global_resetn;
   logic                start;
   logic [DW-1:0]       cfg_data;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [0:BL_WIDTH-1] bl;
   logic [0:WL_WIDTH-1] wl;
   logic                busy, done, err, fabric_resetn;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   ql_bitstream_loader #(
      .BL_WIDTH(BL_WIDTH), .WL_WIDTH(WL_WIDTH), .DATA_WIDTH(DW),
      .WL_PULSE(WL_PULSE), .RELEASE_DELAY(RELEASE_DELAY)
   ) dut (
      .clk(clk), .global_resetn(global_resetn), .start(start),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .bl_config_region_0(bl), .wl_config_region_0(wl),
      .busy(busy), .done(done), .err(err), .fabric_resetn(fabric_resetn)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   task automatic chk(input string name, input longint act, input longint exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic report_and_stop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   // Monitor: each rising word-line pulse pops one expected {row, bit-line image}.
   logic                prev_any = 1'b0;
   int                  pulse_len = 0;
   int                  mon_r;
   logic [EW-1:0]       mon_ent;
   logic [0:BL_WIDTH-1] mon_exp_bl;
   logic [0:BL_WIDTH-1] bl_snap;

   always @(negedge clk) begin
      if (!global_resetn) begin
         prev_any  = 1'b0;
         pulse_len = 0;
      end else if (wl != '0) begin
         chk("wl_onehot", longint'($onehot(wl)), 1);
         if (!prev_any) begin
            mon_r = -1;
            for (int i = 0; i < WL_WIDTH; i++) if (wl[i]) mon_r = i;
            if (exp_q.size() == 0) begin
               chk("pulse_expected", exp_q.size(), 1);
            end else begin
               mon_ent    = exp_q.pop_front();
               mon_exp_bl = mon_ent[BL_WIDTH-1:0];
               chk("row_index", mon_r, longint'(mon_ent[EW-1 -: 16]));
               n_vec++;
               if (bl != mon_exp_bl) begin
                  n_err++;
                  $display("FAIL bl_row%0d: got %h expected %h", mon_r, bl, mon_exp_bl);
               end
               chk("ready_in_pulse", cfg_ready, 0);
            end
            bl_snap   = bl;
            pulse_len = 1;
         end else begin
            pulse_len++;
            chk("bl_stable_in_pulse", longint'(bl != bl_snap), 0);
         end
         prev_any = 1'b1;
      end else begin
         if (prev_any) chk("pulse_len", pulse_len, WL_PULSE);
         prev_any = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [DW-1:0] d);
      int n;
      cfg_valid = 1'b1;
      cfg_data  = d;
      n = 0;
      @(negedge clk);
      while (!cfg_ready) begin
         n++;
         if (n > 100) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: cfg_ready low for %0d cycles, required 1", n);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "loader stopped accepting words");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic stall(input int n);
      cfg_valid = 1'b0;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         chk("stall_wl_zero", longint'(wl != '0), 0);
         chk("stall_ready", cfg_ready, 1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      global_resetn = 1'b0;
      start         = 1'b0;
      cfg_valid     = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_wl", longint'(wl != '0), 0);
      chk("rst_bl", longint'(bl != '0), 0);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_fabric_resetn", fabric_resetn, 0);
      exp_q.delete();
      global_resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // mode 0: row r carries 0xFFFFFFFF in word (r mod WPR), zeros elsewhere; mode 1: random words.
   task automatic run_load(input int mode, input int stall_row, input bit corrupt, input int abort_row);
      logic [DW-1:0]       w[WPR];
      logic [0:BL_WIDTH-1] eb;
      logic [DW-1:0]       acc;
      int                  c0, n;
      bit                  exp_err;
      acc = '0;
      exp_err = corrupt;
`ifndef QL_CFG_CHECKSUM_EN
      exp_err = 1'b0;
`endif
      chk("ready_idle", cfg_ready, 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ready_after_start", cfg_ready, 1);
      chk("busy_after_start", busy, 1);
      c0 = cyc;
      for (int r = 0; r < WL_WIDTH; r++) begin
         for (int k = 0; k < WPR; k++)
            w[k] = (mode == 0) ? ((k == r % WPR) ? 32'hFFFF_FFFF : 32'h0) : $urandom();
         if (mode == 1 && r == 5) w[WPR-1] = 32'hFFFF_FFFF;
         for (int i = 0; i < BL_WIDTH; i++) eb[i] = w[i / DW][i % DW];
         exp_q.push_back({16'(r), eb});
         for (int k = 0; k < WPR; k++) begin
            if (r == abort_row && k == 5) return;
            if (mode == 1 && r == 1 && k == 3) start = 1'b1;
            send_word(w[k]);
            start = 1'b0;
            acc ^= w[k];
            if (r == stall_row && k == 8) stall(10);
         end
      end
`ifdef QL_CFG_CHECKSUM_EN
      send_word(corrupt ? (acc ^ 32'h1) : acc);
`endif
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_seen", done, 1);
      chk("load_cycles", cyc - c0,
          WL_WIDTH * (WPR + WL_PULSE + 1) + ((stall_row >= 0) ? 10 : 0) + CHK_EXTRA);
      chk("scoreboard_drained", exp_q.size(), 0);
      for (int k = 0; k < 7; k++) begin
         chk("fabric_resetn", fabric_resetn, longint'(!exp_err && k >= RELEASE_DELAY));
         chk("done_held", done, 1);
         chk("err_flag", err, longint'(exp_err));
         if (k == 5) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      chk("done_after_start", done, 1);
      chk("ready_in_done", cfg_ready, 0);
      chk("busy_in_done", busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      global_resetn = 1'b0;
      start         = 1'b0;
      cfg_valid     = 1'b0;
      cfg_data      = '0;
      repeat (3) @(posedge clk);
      #1;
      apply_reset();
      run_load(0, -1, 1'b0, -1);
      apply_reset();
      run_load(1, -1, 1'b0, 3);
      apply_reset();
      run_load(1, 7, 1'b1, -1);
      report_and_stop();
   end
endmodule
